// File: rtl/matmul_mac_seq_if.sv
// -----------------------------------------------------------------------------
// matmul_mac_seq_if
// Handshake/data bundle between the operand loader, the matmul_mac_seq block
// and the accumulator/writeback stage.
//
// Parameters:
//   N   matrix dimension
//   DW  operand element width
//   RW  result element width
//
// Signals:
//   in_valid / in_ready   operand-set handshake (loader -> block)
//   acc_mode              1 = add the new product into the held result
//   a_in, b_in            N*N*DW flattened operand matrices, element (r,c) at
//                         [(r*N+c)*DW +: DW]
//   out_valid / out_ready result handshake (block -> writeback)
//   result                N*N*RW flattened result, element (r,c) at
//                         [(r*N+c)*RW +: RW]
//   busy                  block is computing
//   ovf                   sticky accumulate overflow of the current operation
//
// Modports: master = loader/writeback side, slave = the block itself.
// -----------------------------------------------------------------------------
interface matmul_mac_seq_if #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int RW = 2*DW + $clog2(N) + 6
);
  logic              in_valid;
  logic              in_ready;
  logic              acc_mode;
  logic [N*N*DW-1:0] a_in;
  logic [N*N*DW-1:0] b_in;
  logic              out_valid;
  logic              out_ready;
  logic [N*N*RW-1:0] result;
  logic              busy;
  logic              ovf;

  modport master (
    output in_valid, acc_mode, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, busy, ovf
  );

  modport slave (
    input  in_valid, acc_mode, a_in, b_in, out_ready,
    output in_ready, out_valid, result, busy, ovf
  );
endinterface

// File: rtl/matmul_mac_seq.sv
// -----------------------------------------------------------------------------
// matmul_mac_seq
// Sequential N x N unsigned matrix multiplier / accumulator. Computes
// C = A x B (acc_mode=0) or C = C_prev + A x B (acc_mode=1), one result
// element per clock through a single N-term inner-product unit. The result
// register survives between operations so accumulations can be chained.
//
// Parameters:
//   N   matrix dimension (N >= 2)
//   DW  operand element width
//   RW  result element width; must be at least 2*DW+$clog2(N)
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high; returns everything (including the held
//          result) to zero
//   bus    matmul_mac_seq_if.slave: operand handshake, result handshake,
//          busy and sticky ovf
//
// Build option:
//   MATMUL_MAC_SAT_EN  defined   -> accumulate overflow clamps to 2^RW-1
//                      undefined -> accumulate overflow wraps modulo 2^RW
//   ovf reports the overflow in both builds.
//
// Timing: operands accepted at edge t -> elements written on edges
// t+1..t+N*N, out_valid registered high on the last of those edges so a
// consumer sampling on edge t+N*N+1 sees it.
// -----------------------------------------------------------------------------

// Protocol invariants of the block's output handshake.
module matmul_mac_seq_chk (
  input logic clk,
  input logic reset,
  input logic in_ready,
  input logic out_valid,
  input logic out_ready,
  input logic busy
);
  a_ready_valid_excl: assert property (@(posedge clk) disable iff (reset)
    !(in_ready && out_valid));

  a_busy_excl: assert property (@(posedge clk) disable iff (reset)
    busy |-> (!in_ready && !out_valid));

  a_valid_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> out_valid);
endmodule

module matmul_mac_seq #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int RW = 2*DW + $clog2(N) + 6
) (
  input logic             clk,
  input logic             reset,
  matmul_mac_seq_if.slave bus
);

  localparam int NE = N * N;
  localparam int SW = 2*DW + $clog2(N);   // exact width of one inner product
  localparam int IW = $clog2(NE);
  localparam logic [IW-1:0] IDX_LAST = IW'(NE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [NE*DW-1:0]  a_r;
  logic [NE*DW-1:0]  b_r;
  logic              mode_r;
  logic [IW-1:0]     idx_r;
  logic [NE*RW-1:0]  result_r;
  logic              ovf_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              busy_r;

  logic [SW-1:0]     sum_s;
  logic [RW-1:0]     elem_old_s;
  logic [RW:0]       acc_s;
  logic [RW-1:0]     elem_new_s;
  logic              carry_s;

  // Row idx/N of A dotted with column idx%N of B, at full precision.
  function automatic logic [SW-1:0] inner_product(
    input logic [NE*DW-1:0] a_m,
    input logic [NE*DW-1:0] b_m,
    input logic [IW-1:0]    idx
  );
    logic [SW-1:0] acc;
    int            r;
    int            c;
    r   = int'(idx) / N;
    c   = int'(idx) % N;
    acc = '0;
    for (int k = 0; k < N; k++) begin
      acc = acc + SW'(a_m[(r*N+k)*DW +: DW]) * SW'(b_m[(k*N+c)*DW +: DW]);
    end
    return acc;
  endfunction

  // New value for the element at idx: plain product or accumulated product.
  always_comb begin
    sum_s      = inner_product(a_r, b_r, idx_r);
    elem_old_s = result_r[idx_r*RW +: RW];
    // one extra bit on top catches the carry-out of the accumulate add
    acc_s      = {1'b0, elem_old_s} + (RW+1)'(sum_s);
    carry_s    = 1'b0;
    elem_new_s = RW'(sum_s);
    if (mode_r) begin
      carry_s = acc_s[RW];
`ifdef MATMUL_MAC_SAT_EN
      if (acc_s[RW]) begin
        elem_new_s = {RW{1'b1}};
      end else begin
        elem_new_s = acc_s[RW-1:0];
      end
`else
      elem_new_s = acc_s[RW-1:0];
`endif
    end else begin
      carry_s    = 1'b0;
      elem_new_s = RW'(sum_s);
    end
  end

  // Control FSM: operand latch, element sequencing, result handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      mode_r      <= 1'b0;
      idx_r       <= '0;
      result_r    <= '0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_r        <= bus.a_in;
            b_r        <= bus.b_in;
            mode_r     <= bus.acc_mode;
            idx_r      <= '0;
            ovf_r      <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= S_BUSY;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        S_BUSY: begin
          result_r[idx_r*RW +: RW] <= elem_new_s;
          if (carry_s) begin
            ovf_r <= 1'b1;
          end else begin
            ovf_r <= ovf_r;
          end
          if (idx_r == IDX_LAST) begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          // unreachable encoding: recover to an idle, quiet block
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.result    = result_r;
  assign bus.ovf       = ovf_r;

  matmul_mac_seq_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .in_ready  (in_ready_r),
    .out_valid (out_valid_r),
    .out_ready (bus.out_ready),
    .busy      (busy_r)
  );

endmodule

// File: tb/tb_matmul_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_matmul_mac_seq
// Drives two instances in lockstep (RW=40 default width and RW=34 narrow
// width) with directed and random operand sets. Expected matrices come from a
// plain-arithmetic model of C = A x B / C + A x B and are queued at accept
// time; an independent monitor pops and compares whenever out_valid appears.
// -----------------------------------------------------------------------------
module tb_matmul_mac_seq;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int NE  = N * N;
  localparam int RWA = 40;
  localparam int RWB = 34;
`ifdef MATMUL_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [NE*DW-1:0] mat_t;
  typedef struct {
    logic [NE*RWA-1:0] ra;
    logic [NE*RWB-1:0] rb;
    logic              oa;
    logic              ob;
    longint            acc_edge;
  } exp_t;

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  longint cyc   = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     or_mode = 0;
  logic   or_val  = 1'b0;
  exp_t   q[$];
  longint unsigned ca[NE];
  longint unsigned cb[NE];
  exp_t   cur;
  bit     seen = 1'b0;

  matmul_mac_seq_if #(.N(N), .DW(DW), .RW(RWA)) bus_a ();
  matmul_mac_seq_if #(.N(N), .DW(DW), .RW(RWB)) bus_b ();

  matmul_mac_seq #(.N(N), .DW(DW), .RW(RWA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  matmul_mac_seq #(.N(N), .DW(DW), .RW(RWB)) dut_narrow (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned elem(input mat_t m, input int r, input int c);
    return 64'(m[(r*N+c)*DW +: DW]);
  endfunction

  function automatic longint unsigned upd(input longint unsigned old, input longint unsigned s,
                                          input logic m, input int rw, output bit o);
    longint unsigned lim;
    lim = 64'd1 << rw;
    o   = 1'b0;
    if (!m) return s;
    if (old + s >= lim) begin
      o = 1'b1;
      return SAT ? lim - 64'd1 : old + s - lim;
    end
    return old + s;
  endfunction

  task automatic model_apply(input mat_t a, input mat_t b, input logic m, output exp_t e);
    longint unsigned s;
    bit o;
    e.ra = '0; e.rb = '0; e.oa = 1'b0; e.ob = 1'b0; e.acc_edge = 0;
    for (int idx = 0; idx < NE; idx++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += elem(a, idx / N, k) * elem(b, k, idx % N);
      ca[idx] = upd(ca[idx], s, m, RWA, o); e.oa |= o;
      cb[idx] = upd(cb[idx], s, m, RWB, o); e.ob |= o;
      e.ra[idx*RWA +: RWA] = ca[idx][RWA-1:0];
      e.rb[idx*RWB +: RWB] = cb[idx][RWB-1:0];
    end
  endtask

  task automatic drive(input logic v, input mat_t a, input mat_t b, input logic m);
    bus_a.in_valid = v; bus_a.a_in = a; bus_a.b_in = b; bus_a.acc_mode = m;
    bus_b.in_valid = v; bus_b.a_in = a; bus_b.b_in = b; bus_b.acc_mode = m;
  endtask

  // Offer one operand set and wait (bounded) for acceptance.
  task automatic send(input mat_t a, input mat_t b, input logic m, output longint acc);
    exp_t e;
    bit   done;
    done = 1'b0;
    acc  = -1;
    @(negedge clk);
    drive(1'b1, a, b, m);
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus_a.in_ready) begin
        acc = cyc + 1;
        model_apply(a, b, m, e);
        e.acc_edge = acc;
        q.push_back(e);
        done = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, a, b, m);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
      drive(1'b0, a, b, m);
    end
  endtask

  task automatic drain();
    int w;
    for (w = 0; w < 400 && q.size() != 0; w++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  bus_a.in_ready,  1'b1);
    check({tag, "_out_valid"}, bus_a.out_valid, 1'b0);
    check({tag, "_busy"},      bus_a.busy,      1'b0);
    check({tag, "_ovf"},       bus_a.ovf,       1'b0);
    check({tag, "_result"},    bus_a.result,    '0);
    check({tag, "_result_n"},  bus_b.result,    '0);
  endtask

  function automatic mat_t rand_mat(input int sel);
    mat_t m;
    for (int i = 0; i < NE; i++) begin
      case (sel)
        0:       m[i*DW +: DW] = DW'($urandom);
        1:       m[i*DW +: DW] = 16'hFFFF;
        2:       m[i*DW +: DW] = DW'($urandom_range(0, 3));
        default: m[i*DW +: DW] = ($urandom_range(0, 1) != 0) ? 16'hFFFF : DW'($urandom);
      endcase
    end
    return m;
  endfunction

  // Consumer back-pressure: random, or forced by the directed stall test.
  always @(negedge clk) begin
    logic r;
    r = (or_mode == 0) ? ($urandom_range(0, 3) != 0) : or_val;
    bus_a.out_ready = r;
    bus_b.out_ready = r;
  end

  // Scoreboard monitor: pop on the first cycle of each out_valid, then check stability.
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (bus_a.out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
          cur = '{ra: '0, rb: '0, oa: 1'b0, ob: 1'b0, acc_edge: 0};
        end else begin
          cur = q.pop_front();
          check("latency", 64'(cyc + 1 - cur.acc_edge), 64'(NE + 1));
        end
      end
      check("result",      bus_a.result,    cur.ra);
      check("ovf",         bus_a.ovf,       cur.oa);
      check("in_ready_dn", bus_a.in_ready,  1'b0);
      check("busy_dn",     bus_a.busy,      1'b0);
      check("valid_n",     bus_b.out_valid, 1'b1);
      check("result_n",    bus_b.result,    cur.rb);
      check("ovf_n",       bus_b.ovf,       cur.ob);
    end else begin
      seen = 1'b0;
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    mat_t   ident, bseq, ones, a, b;
    longint e1, e2, pulse_edge;
    ident = '0; bseq = '0; ones = '1;
    for (int i = 0; i < NE; i++) begin
      ca[i] = 0; cb[i] = 0;
      ident[i*DW +: DW] = (i / N == i % N) ? 16'd1 : 16'd0;
      bseq[i*DW +: DW]  = DW'(i + 1);
    end
    pulse_edge = 0;
    drive(1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Identity x {1..16}, then all-ones plain and accumulated.
    send(ident, bseq, 1'b0, e1);
    send(ones, ones, 1'b0, e1);
    send(ones, ones, 1'b1, e1);
    drain();

    // Consumer stalls in DONE while a new operand set waits upstream.
    or_val = 1'b0; or_mode = 1;
    send(rand_mat(0), rand_mat(0), 1'b0, e1);
    fork
      send(rand_mat(3), rand_mat(0), 1'b1, e2);
      begin : stall_ctl
        int w;
        @(negedge clk);
        for (w = 0; w < 100 && !bus_a.out_valid; w++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          check("stall_valid",    bus_a.out_valid, 1'b1);
          check("stall_in_ready", bus_a.in_ready,  1'b0);
          @(negedge clk);
        end
        @(posedge clk); or_val = 1'b1;
        @(negedge clk); pulse_edge = cyc + 1;
        @(posedge clk); or_val = 1'b0;
      end
    join
    check("accept_after_pulse", 64'(e2), 64'(pulse_edge + 1));
    or_mode = 0;
    drain();

    // Reset while idx=5 is being processed, then accumulate onto the cleared result.
    a = rand_mat(0); b = rand_mat(0);
    send(a, b, 1'b0, e1);
    while (cyc < e1 + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < NE; i++) begin ca[i] = 0; cb[i] = 0; end
    check_reset_state("midreset");
    b = rand_mat(0);
    send(ident, b, 1'b1, e1);
    drain();

    // Offers during BUSY must be ignored.
    a = rand_mat(0); b = rand_mat(0);
    send(a, b, 1'b0, e1);
    repeat (2) @(negedge clk);
    drive(1'b1, ~a, ~b, 1'b1);
    repeat (3) @(negedge clk);
    drive(1'b0, a, b, 1'b0);
    drain();

    // Random traffic with random modes and back-pressure.
    for (int t = 0; t < 24; t++) begin
      a = rand_mat($urandom_range(0, 3));
      b = rand_mat($urandom_range(0, 3));
      send(a, b, 1'($urandom_range(0, 1)), e1);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
